// File: rtl/dsram_responder_pkg.sv
// Shared definitions for the sram-like data responder: FSM encoding,
// byte-lane geometry and the read/write-select convention.
package dsram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int WORD_W    = NUM_LANES * LANE_W;

  // wen == LANES_NONE is a read; any set bit makes the request a write.
  localparam logic [NUM_LANES-1:0] LANES_NONE = '0;

  // Out-of-range requests must never reach the RAM as writes.
  function automatic logic [NUM_LANES-1:0] wr_lanes(input logic [NUM_LANES-1:0] wen,
                                                    input logic                 in_range);
    return in_range ? wen : LANES_NONE;
  endfunction

endpackage

// File: rtl/dsram_responder_bram_be.sv
// Single-port word RAM with per-byte write enables and a registered,
// read-before-write output so it maps onto block RAM.
module dsram_responder_bram_be
  import dsram_responder_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic [NUM_LANES-1:0] we_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [WORD_W-1:0]    wdata_i,
  output logic [WORD_W-1:0]    rdata_o
);

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem[addr_i];
      for (int i = 0; i < NUM_LANES; i++) begin
        if (we_i[i]) mem[addr_i][i*LANE_W +: LANE_W] <= wdata_i[i*LANE_W +: LANE_W];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dsram_responder.sv
// Responder for the memory stage: latches one request, waits WAIT cycles,
// performs the RAM access, then emits a one-cycle response with stall released.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int          ADDR_W = 12,
  parameter int          WAIT   = 2,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        stall,
  output logic        err
);

  localparam int CW = (WAIT < 1) ? 1 : $clog2(WAIT + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] waddr_q;
  logic [3:0]        wen_q;
  logic [31:0]       wdata_q;
  logic              inr_q;
  logic [31:0]       rdata_q;

  logic              idle, accept, inr_live;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wd, ram_rd;

  assign idle     = (state_q == ST_IDLE);
  assign accept   = idle && en;
  assign inr_live = (addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_RESP) rdata_q <= rdata;
    end
  end

  // Request copy; only this is used after acceptance so requester changes are harmless.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      waddr_q <= addr[ADDR_W+1:2];
      wen_q   <= wen;
      wdata_q <= wdata;
      inr_q   <= inr_live;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = (WAIT > 0) ? ST_WAIT : ST_RESP;
          cnt_d   = (WAIT > 0) ? CW'(WAIT - 1) : '0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With WAIT=0 the access coincides with acceptance, so the live inputs feed the RAM.
  always_comb begin
    ram_en   = !rst && ((accept && (WAIT == 0)) || ((state_q == ST_WAIT) && (cnt_q == '0)));
    ram_addr = idle ? addr[ADDR_W+1:2] : waddr_q;
    ram_we   = idle ? wr_lanes(wen, inr_live) : wr_lanes(wen_q, inr_q);
    ram_wd   = idle ? wdata : wdata_q;
  end

  always_comb begin
    rvalid = (state_q == ST_RESP);
    err    = rvalid && !inr_q;
    stall  = accept || (state_q == ST_WAIT);
    rdata  = rvalid ? (inr_q ? ram_rd : 32'h0) : rdata_q;
  end

  dsram_responder_bram_be #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wd),
    .rdata_o (ram_rd)
  );

endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: one instance with WAIT=0 and one with WAIT=2,
// directed table, hand sequences and random traffic against a word-array model.
module tb_dsram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, en0, rvalid0, stall0, err0;
  logic [3:0]  wen0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        rst2, en2, rvalid2, stall2, err2;
  logic [3:0]  wen2;
  logic [31:0] addr2, wdata2, rdata2;

  dsram_responder #(.ADDR_W(12), .WAIT(0), .BASE(32'h0)) u_dut0 (
    .clk(clk), .rst(rst0), .en(en0), .wen(wen0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .rvalid(rvalid0), .stall(stall0), .err(err0));

  dsram_responder #(.ADDR_W(12), .WAIT(2), .BASE(32'h0)) u_dut2 (
    .clk(clk), .rst(rst2), .en(en2), .wen(wen2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .rvalid(rvalid2), .stall(stall2), .err(err2));

  int ncmp = 0;
  int nerr = 0;
  int WT [2] = '{0, 2};

  // Reference: a plain word array per instance, plus which words hold known data.
  logic [31:0] mem   [2][4096];
  bit          known [2][4096];

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          chk_rd;
    bit          exp_err;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin en0 = e; wen0 = w; addr0 = a; wdata0 = wd; end
    else        begin en2 = e; wen2 = w; addr2 = a; wdata2 = wd; end
  endtask

  task automatic sample(input int d, output logic [31:0] rd, output logic rv,
                        output logic st, output logic er);
    if (d == 0) begin rd = rdata0; rv = rvalid0; st = stall0; er = err0; end
    else        begin rd = rdata2; rv = rvalid2; st = stall2; er = err2; end
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin @(negedge clk); drive(d, 1'b0, 4'h0, 32'h0, 32'h0); end
  endtask

  function automatic void model(input int d, input logic [3:0] w, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] e,
                                output bit c, output bit er);
    int i;
    i = int'(a[13:2]);
    if (a[31:14] != 18'h0) begin
      e = 32'h0; c = 1'b1; er = 1'b1;
      return;
    end
    e = mem[d][i]; c = known[d][i]; er = 1'b0;
    for (int l = 0; l < 4; l++) if (w[l]) mem[d][i][8*l +: 8] = wd[8*l +: 8];
    if (w == 4'hF) known[d][i] = 1'b1;
  endfunction

  // One request held until the response; checks latency, stall profile and data.
  task automatic txn(input int d, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input bit chk_rd,
                     input bit exp_err, input bit mutate, input string nm);
    logic [31:0] rd;
    logic rv, st, er;
    int n, at;
    bit got;
    n = 0; at = -1; got = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) drive(d, 1'b1, w, a, wd);
      else if (mutate && c == 1) drive(d, 1'b1, w, 32'h20, 32'h1);
      #1;
      sample(d, rd, rv, st, er);
      if (rv) begin got = 1'b1; at = c; break; end
      if (st) n++;
    end
    chk({nm, " resp seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, " resp cycle"}, at, WT[d] + 1);
      chk({nm, " stall cycles"}, n, WT[d] + 1);
      chk({nm, " stall in resp"}, 32'(st), 32'd0);
      chk({nm, " err"}, 32'(er), 32'(exp_err));
      if (chk_rd) chk({nm, " rdata"}, rd, exp_rd);
    end
  endtask

  task automatic req(input int d, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] wd, input bit mutate, input string nm);
    logic [31:0] e;
    bit c, er;
    model(d, w, a, wd, e, c, er);
    txn(d, w, a, wd, e, c, er, mutate, nm);
  endtask

  initial begin
    logic [31:0] rd, e, a;
    logic rv, st, er;
    logic [3:0] w;
    bit c, x;

    tbl[0] = '{4'hF, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[1] = '{4'h0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    tbl[2] = '{4'h4, 32'h10,       32'h00AA0000, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[3] = '{4'h0, 32'h13,       32'h0,        32'hDEAABEEF, 1'b1, 1'b0};
    tbl[4] = '{4'hF, 32'h0,        32'h12345678, 32'h0,        1'b0, 1'b0};
    tbl[5] = '{4'hF, 32'h0001_0000, 32'hCAFEF00D, 32'h0,       1'b1, 1'b1};
    tbl[6] = '{4'h0, 32'h0,        32'h0,        32'h12345678, 1'b1, 1'b0};
    tbl[7] = '{4'h0, 32'h0001_0000, 32'h0,       32'h0,        1'b1, 1'b1};

    rst0 = 1'b1; rst2 = 1'b1;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst0 = 1'b0; rst2 = 1'b0; #1;
    for (int d = 0; d < 2; d++) begin
      sample(d, rd, rv, st, er);
      chk($sformatf("reset rdata d%0d", d), rd, 32'h0);
      chk($sformatf("reset rvalid d%0d", d), 32'(rv), 32'd0);
      chk($sformatf("reset stall d%0d", d), 32'(st), 32'd0);
      chk($sformatf("reset err d%0d", d), 32'(er), 32'd0);
    end

    // Directed table on the WAIT=2 instance; model kept in step, table values compared.
    for (int i = 0; i < 8; i++) begin
      model(1, tbl[i].wen, tbl[i].addr, tbl[i].wdata, e, c, x);
      txn(1, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].chk_rd,
          tbl[i].exp_err, 1'b0, $sformatf("tbl%0d", i));
      idle(1, 1);
    end
    sample(1, rd, rv, st, er);
    chk("hold rdata after resp", rd, 32'h0);
    chk("hold err after resp", 32'(er), 32'd0);

    // Reset in the last WAIT cycle of a write: nothing committed, outputs cleared.
    @(negedge clk); drive(1, 1'b1, 4'hF, 32'h10, 32'h11111111);
    @(negedge clk);
    @(negedge clk); rst2 = 1'b1; drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); rst2 = 1'b0; #1;
    sample(1, rd, rv, st, er);
    chk("rst-in-wait stall", 32'(st), 32'd0);
    chk("rst-in-wait rvalid", 32'(rv), 32'd0);
    chk("rst-in-wait rdata", rd, 32'h0);
    @(negedge clk); #1;
    sample(1, rd, rv, st, er);
    chk("rst-in-wait idle rvalid", 32'(rv), 32'd0);
    txn(1, 4'h0, 32'h10, 32'h0, 32'hDEAABEEF, 1'b1, 1'b0, 1'b0, "rst old word");

    // Inputs changed during WAIT must not redirect the write.
    idle(1, 1);
    req(1, 4'hF, 32'h20, 32'h20202020, 1'b0, "pre 0x20");
    req(1, 4'hF, 32'h30, 32'h55AA55AA, 1'b1, "mutated write");
    idle(1, 1);
    txn(1, 4'h0, 32'h30, 32'h0, 32'h55AA55AA, 1'b1, 1'b0, 1'b0, "mut orig addr");
    txn(1, 4'h0, 32'h20, 32'h0, 32'h20202020, 1'b1, 1'b0, 1'b0, "mut other addr");
    idle(1, 1);

    // WAIT=0 back-to-back with en held through RESP: 2-cycle period.
    req(0, 4'hF, 32'h4, 32'hA5A5A5A5, 1'b0, "b2b w");
    txn(0, 4'h0, 32'h4, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, "b2b r1");
    txn(0, 4'h0, 32'h4, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, "b2b r2");
    txn(0, 4'hF, 32'h0001_0000, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0, "b2b oor");
    @(negedge clk); drive(0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    sample(0, rd, rv, st, er);
    chk("en in resp ignored rvalid", 32'(rv), 32'd0);
    chk("en in resp ignored stall", 32'(st), 32'd0);
    txn(0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "alias probe");
    txn(0, 4'h0, 32'h4, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, "after oor");

    // Random traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 80; k++) begin
        a = {$urandom_range(0, 15), 2'b00} | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 14);
        w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        req(d, w, a, $urandom, 1'b0, $sformatf("rnd d%0d #%0d", d, k));
        idle(d, $urandom_range(0, 1));
      end
      idle(d, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
